mem_dma_engine: RTL and testbench
=================================

// Module: mem_dma_engine
// PURPOSE
//  Word-granular copy engine; initiator side of a main_memory port (address/rd_en/wr_en/rd_data).
//  Accepts one descriptor (src, dst, length) and moves words one at a time through a single memory port.
//  Lets the processor offload framebuffer/buffer moves while the other port stays free for scanout/CPU.
// PARAMETERS
//  CAPACITY_BYTES  4096  byte size of the target memory; address width AW = $clog2(CAPACITY_BYTES)
//  WORD_BYTES      4     bytes per word; data width DW = 8*WORD_BYTES
//  RD_LATENCY      1     cycles from rd_en to valid mem_rd_data (>=1)
//  LEN_W           16    width of the word-count field
// PORTS
//  clk            in   1           single clock
//  reset          in   1           asynchronous, active-high
//  start          in   1           one-cycle pulse; latch descriptor when IDLE
//  src_addr       in   AW          byte address of first source word
//  dst_addr       in   AW          byte address of first destination word
//  length_words   in   LEN_W       words to move
//  abort          in   1           stop transfer at next cycle boundary
//  fill           in   1           descriptor mode: 1 = fill (MEM_DMA_FILL_EN only)
//  fill_value     in   DW          pattern for fill mode (MEM_DMA_FILL_EN only)
//  busy           out  1           transfer in progress
//  done           out  1           one-cycle completion pulse
//  mem_address    out  AW          byte address to memory port
//  mem_rd_en      out  1           read strobe
//  mem_rd_data    in   DW          read data, valid RD_LATENCY cycles after mem_rd_en
//  mem_wr_data    out  DW          write data
//  mem_wr_en      out  WORD_BYTES  per-byte write enables (all-ones or all-zero)
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_address=0, mem_wr_data=0, counters 0.
//  - Outputs registered. FSM: IDLE -> READ -> WAIT -> WRITE -> (READ | FINISH) -> IDLE.
//  - IDLE: start=1 latches src/dst/len. Low log2(WORD_BYTES) address bits forced to 0.
//    len=0 -> FINISH directly, no memory access. Otherwise -> READ. start outside IDLE is ignored.
//  - READ (1 cycle): mem_address=src_ptr, mem_rd_en=1.
//  - WAIT (RD_LATENCY cycles): strobes low; on final WAIT cycle capture mem_rd_data into data_q.
//  - WRITE (1 cycle): mem_address=dst_ptr, mem_wr_data=data_q, mem_wr_en='1.
//    src_ptr/dst_ptr += WORD_BYTES, remaining -= 1. remaining reaches 0 -> FINISH, else READ.
//  - FINISH (1 cycle): done=1, busy still 1; next IDLE. Per word: 2+RD_LATENCY cycles.
//  - busy=1 in every non-IDLE state. mem_rd_en and mem_wr_en are never high in the same cycle.
//  - Pointers wrap modulo CAPACITY_BYTES (AW-bit arithmetic); wrap is not an error.
//  - Overlapping src/dst copies strictly ascending; no hazard handling.
//  - abort (any non-IDLE state): next cycle IDLE, strobes 0, no done pulse.
//    A WRITE in the abort cycle still completes.
//  - start and abort in the same cycle while IDLE: start wins, abort ignored.
//  - Reset mid-transfer: immediate return to reset values; no partial write after reset deasserts.
// CONFIGURATION
//  MEM_DMA_FILL_EN defined:
//    descriptor with fill=1 latches fill_value into data_q.
//    FSM skips READ/WAIT: IDLE -> WRITE -> WRITE ... -> FINISH, 1 word/cycle. src_addr ignored.
//  MEM_DMA_FILL_EN undefined:
//    fill and fill_value ports present but ignored; every descriptor is a copy; no fill logic.
// STRUCTURE
//  mem_dma_pkg: typedef enum dma_state_e {IDLE, READ, WAIT, WRITE, FINISH}.
//  mem_dma_pkg: typedef struct dma_desc_t {src, dst, len, fill}; function word_align().
//  No sub-module; a single FSM plus pointer/count/latency counters.
//  Bench instantiates main_memory as the responder on one port.
// TESTING
//  - Reset: assert reset mid-transfer -> all outputs 0 same cycle (async); no writes after release.
//  - Copy: src=0x100, dst=0x200, len=4, mem preloaded 0xA0..0xA3.
//    Result: 0x200..0x20C = 0xA0..0xA3; done pulses once at cycle 1+4*3; busy drops next cycle.
//  - len=0: start -> done next cycle+1; no mem_rd_en/mem_wr_en ever asserted.
//  - Wrap: src=0xFF8, dst=0x000, len=4 (CAPACITY 4096) -> reads 0xFF8, 0xFFC, 0x000, 0x004 in order.
//  - Abort: len=8, abort in 3rd WAIT -> exactly 2 words written, no done, busy=0 next cycle.
//    A start while busy is ignored.
//  - Fill (MEM_DMA_FILL_EN): fill=1, fill_value=0xDEADBEEF, dst=0x40, len=3.
//    Result: 3 consecutive mem_wr_en cycles, mem_rd_en never high, done next cycle.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// -----------------------------------------------------------------------------
// mem_dma_pkg
// Shared definitions for the mem_dma_engine word-copy engine:
//   - memory geometry (byte capacity, word size, descriptor length width) and
//     the address/data widths derived from it
//   - dma_state_e : engine FSM states
//   - dma_desc_t  : latched transfer descriptor, which also serves as the
//                   live source/destination pointers and the remaining count
//   - word_align(): clears the byte-offset bits of an address
// The optional fill mode is controlled by the macro MEM_DMA_FILL_EN, which is
// consumed in mem_dma_engine.sv.
// -----------------------------------------------------------------------------
package mem_dma_pkg;

    localparam int CAPACITY_BYTES = 4096;
    localparam int WORD_BYTES     = 4;
    localparam int LEN_W          = 16;
    localparam int AW             = $clog2(CAPACITY_BYTES);
    localparam int DW             = 8 * WORD_BYTES;

    localparam logic [AW-1:0] WORD_OFS_MASK = AW'(WORD_BYTES - 1);
    localparam logic [AW-1:0] WORD_STEP     = AW'(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        FINISH
    } dma_state_e;

    typedef struct packed {
        logic [AW-1:0]    src;
        logic [AW-1:0]    dst;
        logic [LEN_W-1:0] len;
        logic             fill;
    } dma_desc_t;

    function automatic logic [AW-1:0] word_align(input logic [AW-1:0] addr);
        return addr & ~WORD_OFS_MASK;
    endfunction

endpackage

// File: rtl/mem_dma_engine.sv
// -----------------------------------------------------------------------------
// mem_dma_engine
// Word-granular copy engine acting as initiator on one main_memory port. It
// takes a single descriptor (src, dst, length in words) and moves the words
// one by one: READ -> WAIT (RD_LATENCY cycles) -> WRITE per word, then a
// one-cycle FINISH that pulses done. Pointers wrap modulo the memory size.
//
// Optional feature: define MEM_DMA_FILL_EN to enable fill mode (fill=1 writes
// fill_value to len consecutive words at one word per cycle, with no reads).
// Without the macro, fill and fill_value are accepted but ignored.
//
// Memory geometry (capacity, word size, length width) is defined in
// mem_dma_pkg so that ports and the descriptor struct share one definition.
//
// Ports
//   clk           in   clock
//   reset         in   asynchronous, active-high reset
//   start         in   one-cycle pulse, latches the descriptor when idle
//   src_addr      in   byte address of first source word
//   dst_addr      in   byte address of first destination word
//   length_words  in   number of words to move
//   abort         in   return to idle at the next clock edge
//   fill          in   descriptor mode, 1 = fill (MEM_DMA_FILL_EN only)
//   fill_value    in   fill pattern (MEM_DMA_FILL_EN only)
//   busy          out  transfer in progress
//   done          out  one-cycle completion pulse
//   mem_address   out  byte address to the memory port
//   mem_rd_en     out  read strobe
//   mem_rd_data   in   read data, valid RD_LATENCY cycles after mem_rd_en
//   mem_wr_data   out  write data
//   mem_wr_en     out  per-byte write enables (all ones or all zeros)
// -----------------------------------------------------------------------------
module mem_dma_engine
    import mem_dma_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [AW-1:0]         src_addr,
    input  logic [AW-1:0]         dst_addr,
    input  logic [LEN_W-1:0]      length_words,
    input  logic                  abort,
    input  logic                  fill,
    input  logic [DW-1:0]         fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         mem_address,
    output logic                  mem_rd_en,
    input  logic [DW-1:0]         mem_rd_data,
    output logic [DW-1:0]         mem_wr_data,
    output logic [WORD_BYTES-1:0] mem_wr_en
);

    localparam int               LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

    dma_state_e       r_state,   w_state_nxt;
    dma_desc_t        r_desc,    w_desc_nxt;
    logic [DW-1:0]    r_data_q,  w_data_nxt;
    logic [LAT_W-1:0] r_lat_cnt, w_lat_nxt;
    logic             w_fill_req;

    logic                  r_busy;
    logic                  r_done;
    logic [AW-1:0]         r_mem_address;
    logic                  r_mem_rd_en;
    logic [DW-1:0]         r_mem_wr_data;
    logic [WORD_BYTES-1:0] r_mem_wr_en;

`ifdef MEM_DMA_FILL_EN
    assign w_fill_req = fill;
`else
    // Fill ports exist for interface compatibility only in this build.
    logic w_unused_fill;
    assign w_unused_fill = ^{fill, fill_value};
    assign w_fill_req    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_desc_nxt  = r_desc;
        w_data_nxt  = r_data_q;
        w_lat_nxt   = r_lat_cnt;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_desc_nxt.src  = word_align(src_addr);
                    w_desc_nxt.dst  = word_align(dst_addr);
                    w_desc_nxt.len  = length_words;
                    w_desc_nxt.fill = w_fill_req;
                    if (length_words == '0) begin
                        w_state_nxt = FINISH;
`ifdef MEM_DMA_FILL_EN
                    end else if (fill) begin
                        w_data_nxt  = fill_value;
                        w_state_nxt = WRITE;
`endif
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            READ: begin
                w_lat_nxt   = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // Data is valid on the last latency cycle; capture it there.
                if (r_lat_cnt == LAT_LAST) begin
                    w_data_nxt  = mem_rd_data;
                    w_state_nxt = WRITE;
                end else begin
                    w_lat_nxt = r_lat_cnt + LAT_W'(1);
                end
            end
            WRITE: begin
                w_desc_nxt.src = r_desc.src + WORD_STEP;
                w_desc_nxt.dst = r_desc.dst + WORD_STEP;
                w_desc_nxt.len = r_desc.len - LEN_W'(1);
                if (r_desc.len == LEN_W'(1)) begin
                    w_state_nxt = FINISH;
                end else if (r_desc.fill) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_state_nxt = READ;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides everything except a start accepted while idle.
        if (abort && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // State, descriptor and data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_desc    <= '0;
            r_data_q  <= '0;
            r_lat_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state   <= w_state_nxt;
            r_desc    <= w_desc_nxt;
            r_data_q  <= w_data_nxt;
            r_lat_cnt <= w_lat_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Registered memory-port and status outputs, decoded from the next state
    // so they line up with the state they belong to.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_address <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_wr_data <= '0;
            r_mem_wr_en   <= '0;
        end else begin
            r_busy      <= (w_state_nxt != IDLE);
            r_done      <= (w_state_nxt == FINISH);
            r_mem_rd_en <= (w_state_nxt == READ);
            r_mem_wr_en <= {WORD_BYTES{w_state_nxt == WRITE}};
            unique case (w_state_nxt)
                READ:    r_mem_address <= w_desc_nxt.src;
                WRITE:   r_mem_address <= w_desc_nxt.dst;
                default: r_mem_address <= '0;
            endcase
            r_mem_wr_data <= (w_state_nxt == WRITE) ? w_data_nxt : '0;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_address = r_mem_address;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_wr_en   = r_mem_wr_en;

endmodule

// File: tb/tb_mem_dma_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_dma_engine
// Self-checking bench for mem_dma_engine. A behavioural word memory answers
// the DUT's port with one cycle of read latency. A reference model computes
// the expected read/write address sequences, write data, memory image and
// done timing for each descriptor from plain ascending-copy arithmetic.
// When MEM_DMA_FILL_EN is defined the fill descriptors are expected to fill;
// otherwise they are expected to behave as ordinary copies.
// -----------------------------------------------------------------------------
module tb_mem_dma_engine;

    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int WB     = 4;
    localparam int LEN_W  = 16;
    localparam int CAP    = 4096;
    localparam int NWORDS = CAP / WB;

    logic             clk          = 1'b0;
    logic             reset        = 1'b0;
    logic             start        = 1'b0;
    logic [AW-1:0]    src_addr     = '0;
    logic [AW-1:0]    dst_addr     = '0;
    logic [LEN_W-1:0] length_words = '0;
    logic             abort        = 1'b0;
    logic             fill         = 1'b0;
    logic [DW-1:0]    fill_value   = '0;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_address;
    logic             mem_rd_en;
    logic [DW-1:0]    mem_rd_data;
    logic [DW-1:0]    mem_wr_data;
    logic [WB-1:0]    mem_wr_en;

    mem_dma_engine #(.RD_LATENCY(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length_words (length_words),
        .abort        (abort),
        .fill         (fill),
        .fill_value   (fill_value),
        .busy         (busy),
        .done         (done),
        .mem_address  (mem_address),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en)
    );

    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    logic [DW-1:0] ram [NWORDS];
    logic [DW-1:0] img [NWORDS];
    logic          bd_load = 1'b0;
    int unsigned   cyc     = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bd_load) begin
            for (int i = 0; i < NWORDS; i++) ram[i] <= img[i];
        end else if (mem_wr_en != '0) begin
            ram[mem_address[AW-1:2]] <= mem_wr_data;
        end
        if (mem_rd_en) mem_rd_data <= ram[mem_address[AW-1:2]];
        else           mem_rd_data <= 'x;
    end

    // ---------------- bus monitor ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_ev_t;

    wr_ev_t        wr_log [$];
    logic [AW-1:0] rd_log [$];
    int unsigned   overlap_cnt = 0;
    int unsigned   partial_cnt = 0;
    int unsigned   done_cnt    = 0;

    always @(negedge clk) begin
        if (mem_wr_en != '0) wr_log.push_back('{mem_address, mem_wr_data});
        if (mem_rd_en)       rd_log.push_back(mem_address);
        if (mem_rd_en && (mem_wr_en != '0))      overlap_cnt <= overlap_cnt + 1;
        if ((mem_wr_en != '0) && (mem_wr_en != '1)) partial_cnt <= partial_cnt + 1;
        if (done)            done_cnt <= done_cnt + 1;
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [NWORDS];
    logic [AW-1:0] exp_rd [$];
    wr_ev_t        exp_wr [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Mid-low-phase sampling point: all DUT outputs and monitor updates settled.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Ascending word copy (or fill) of nwr words, applied to ref_mem in order.
    task automatic model_xfer(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                              input int nwr, input logic f, input logic [DW-1:0] fv);
        int            s;
        int            d;
        logic [DW-1:0] w;
        exp_rd.delete();
        exp_wr.delete();
        s = (int'(src) / WB) * WB;
        d = (int'(dst) / WB) * WB;
        for (int i = 0; i < nwr; i++) begin
            if (f) begin
                w = fv;
            end else begin
                exp_rd.push_back(AW'(s));
                w = ref_mem[s / WB];
            end
            exp_wr.push_back('{AW'(d), w});
            ref_mem[d / WB] = w;
            s = (s + WB) % CAP;
            d = (d + WB) % CAP;
        end
    endtask

    task automatic check_logs(input string tag, input int rd_base, input int wr_base);
        check({tag, " rd count"}, 64'(rd_log.size() - rd_base), 64'(exp_rd.size()));
        check({tag, " wr count"}, 64'(wr_log.size() - wr_base), 64'(exp_wr.size()));
        for (int i = 0; i < exp_rd.size(); i++)
            if (rd_base + i < rd_log.size())
                check($sformatf("%s rd_addr[%0d]", tag, i), 64'(rd_log[rd_base + i]), 64'(exp_rd[i]));
        for (int i = 0; i < exp_wr.size(); i++)
            if (wr_base + i < wr_log.size()) begin
                check($sformatf("%s wr_addr[%0d]", tag, i), 64'(wr_log[wr_base + i].a), 64'(exp_wr[i].a));
                check($sformatf("%s wr_data[%0d]", tag, i), 64'(wr_log[wr_base + i].d), 64'(exp_wr[i].d));
            end
    endtask

    task automatic check_mem(input string tag);
        int nbad = 0;
        for (int i = 0; i < NWORDS; i++)
            if (ram[i] !== ref_mem[i]) nbad++;
        check({tag, " mem image bad words"}, 64'(nbad), 64'd0);
    endtask

    // Full descriptor: issue, wait for done (bounded), check timing, bus and memory.
    task automatic run_xfer(input string tag, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input int len, input logic f, input logic [DW-1:0] fv,
                            input logic with_abort);
        int          rd_base;
        int          wr_base;
        int unsigned done_base;
        int unsigned ovl_base;
        int unsigned part_base;
        int unsigned c0;
        int          per;
        int          k;
        logic        eff_fill;
`ifdef MEM_DMA_FILL_EN
        eff_fill = f;
`else
        eff_fill = 1'b0;
`endif
        per = eff_fill ? 1 : 3;
        model_xfer(src, dst, len, eff_fill, fv);
        rd_base   = rd_log.size();
        wr_base   = wr_log.size();
        done_base = done_cnt;
        ovl_base  = overlap_cnt;
        part_base = partial_cnt;

        start        = 1'b1;
        src_addr     = src;
        dst_addr     = dst;
        length_words = LEN_W'(len);
        fill         = f;
        fill_value   = fv;
        abort        = with_abort;
        c0           = cyc;
        step();
        start = 1'b0;
        abort = 1'b0;
        k     = 0;
        while ((done !== 1'b1) && (k < len * per + 20)) begin
            step();
            k++;
        end
        check({tag, " done seen"},    64'(done), 64'd1);
        check({tag, " done cycle"},   64'(cyc - c0), 64'(1 + len * per));
        check({tag, " busy at done"}, 64'(busy), 64'd1);
        step();
        check({tag, " busy after done"}, 64'(busy), 64'd0);
        check({tag, " done one pulse"},  64'(done_cnt - done_base), 64'd1);
        check({tag, " rd/wr overlap"},   64'(overlap_cnt - ovl_base), 64'd0);
        check({tag, " partial wr_en"},   64'(partial_cnt - part_base), 64'd0);
        check_logs(tag, rd_base, wr_base);
        check_mem(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rd_base;
        int          wr_base;
        int unsigned done_base;
        int          k;

        // ---------------- reset values ----------------
        #1 reset = 1'b1;
        #1;
        check("reset busy",        64'(busy),        64'd0);
        check("reset done",        64'(done),        64'd0);
        check("reset mem_rd_en",   64'(mem_rd_en),   64'd0);
        check("reset mem_wr_en",   64'(mem_wr_en),   64'd0);
        check("reset mem_address", 64'(mem_address), 64'd0);
        check("reset mem_wr_data", 64'(mem_wr_data), 64'd0);

        for (int i = 0; i < NWORDS; i++) img[i] = $urandom;
        for (int i = 0; i < 4; i++) img['h100 / WB + i] = DW'('hA0 + i);
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = img[i];
        step();
        bd_load = 1'b1;
        step();
        bd_load = 1'b0;
        step();
        reset = 1'b0;
        step();

        // ---------------- directed descriptors ----------------
        run_xfer("copy4",  12'h100, 12'h200, 4, 1'b0, '0, 1'b0);
        check("copy4 word0", 64'(ram['h200 / WB]),     64'h0A0);
        check("copy4 word3", 64'(ram['h20C / WB]),     64'h0A3);
        run_xfer("len0",   12'h100, 12'h300, 0, 1'b0, '0, 1'b0);
        run_xfer("wrap",   12'hFF8, 12'h000, 4, 1'b0, '0, 1'b0);
        run_xfer("unalign",12'h103, 12'h402, 3, 1'b0, '0, 1'b0);
        run_xfer("start+abort idle", 12'h200, 12'h500, 2, 1'b0, '0, 1'b1);
        run_xfer("fill",   12'h100, 12'h040, 3, 1'b1, 32'hDEADBEEF, 1'b0);

        // ---------------- abort in third WAIT, start while busy ignored ----------------
        model_xfer(12'h100, 12'h600, 2, 1'b0, '0);
        exp_rd.push_back(12'h108);
        rd_base      = rd_log.size();
        wr_base      = wr_log.size();
        done_base    = done_cnt;
        start        = 1'b1;
        src_addr     = 12'h100;
        dst_addr     = 12'h600;
        length_words = 16'd8;
        fill         = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step();
            start = 1'b0;
            if (j == 4) begin
                start        = 1'b1;
                src_addr     = 12'h300;
                dst_addr     = 12'h380;
                length_words = 16'd5;
            end
            if (j == 8) begin
                check("abort busy in wait", 64'(busy), 64'd1);
                abort = 1'b1;
            end
        end
        step();
        abort = 1'b0;
        check("abort busy next",  64'(busy),      64'd0);
        check("abort rd_en next", 64'(mem_rd_en), 64'd0);
        check("abort wr_en next", 64'(mem_wr_en), 64'd0);
        repeat (10) step();
        check("abort no done", 64'(done_cnt - done_base), 64'd0);
        check_logs("abort", rd_base, wr_base);
        check_mem("abort");

        // ---------------- randomized descriptors ----------------
        for (int r = 0; r < 8; r++) begin
            run_xfer($sformatf("rand%0d", r), AW'($urandom_range(0, CAP - 1)),
                     AW'($urandom_range(0, CAP - 1)), int'($urandom_range(1, 10)),
                     1'($urandom_range(0, 1)), $urandom, 1'b0);
        end

        // ---------------- asynchronous reset mid-transfer ----------------
        start        = 1'b1;
        src_addr     = 12'h100;
        dst_addr     = 12'h800;
        length_words = 16'd4;
        fill         = 1'b0;
        step();
        start = 1'b0;
        k     = 0;
        while ((mem_wr_en === '0) && (k < 20)) begin
            step();
            k++;
        end
        check("midrst reached write", 64'(mem_wr_en), 64'hF);
        #2 reset = 1'b1;
        #1;
        check("midrst busy",        64'(busy),        64'd0);
        check("midrst done",        64'(done),        64'd0);
        check("midrst mem_rd_en",   64'(mem_rd_en),   64'd0);
        check("midrst mem_wr_en",   64'(mem_wr_en),   64'd0);
        check("midrst mem_address", 64'(mem_address), 64'd0);
        check("midrst mem_wr_data", 64'(mem_wr_data), 64'd0);
        step();
        reset     = 1'b0;
        rd_base   = rd_log.size();
        wr_base   = wr_log.size();
        done_base = done_cnt;
        repeat (10) step();
        check("midrst no reads after",  64'(rd_log.size() - rd_base), 64'd0);
        check("midrst no writes after", 64'(wr_log.size() - wr_base), 64'd0);
        check("midrst no done after",   64'(done_cnt - done_base),    64'd0);
        check("midrst idle busy",       64'(busy),                    64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
